// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a small ARMv8-style subset: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a sticky ERROR state for undefined opcodes. Outputs decode from state plus registered instruction class.
module multicycle_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        zero,
  input  logic        flag_n,
  input  logic        flag_v,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg2loc,
  output logic        shift_dir,
  output logic        flag_en,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        illegal
);

  localparam int unsigned OPC_W = 11;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_SHIFT = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_COND   = 2'b01;
  localparam logic [1:0] PC_UNCOND = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_e;

  typedef enum logic [3:0] {
    I_NONE, I_ADDI, I_ADDS, I_SUBS, I_LSL, I_LSR, I_MUL,
    I_LDUR, I_STUR, I_B, I_BLT, I_CBZ
  } instr_e;

  state_e             state_q, state_d;
  instr_e             instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exec_last;
  logic               br_taken;

  // Opcode to instruction class; I_NONE marks an undefined opcode
  function automatic instr_e decode_op(input logic [OPC_W-1:0] op);
    instr_e r;
    r = I_NONE;
    casez (op)
      11'b1001000100?: r = I_ADDI;
      11'b10101011000: r = I_ADDS;
      11'b11101011000: r = I_SUBS;
      11'b11010011011: r = I_LSL;
      11'b11010011010: r = I_LSR;
      11'b10011011000: r = I_MUL;
      11'b11111000010: r = I_LDUR;
      11'b11111000000: r = I_STUR;
      11'b000101?????: r = I_B;
      11'b01010100???: r = I_BLT;
      11'b10110100???: r = I_CBZ;
      default:         r = I_NONE;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      instr_q <= I_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only MUL stretches EXEC; every other class finishes EXEC in one cycle
  assign exec_last = (instr_q != I_MUL) || (cnt_q == CNT_W'(MUL_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    br_taken   = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    shift_dir  = 1'b0;
    flag_en    = 1'b0;
    pc_src     = PC_SEQ;
    alu_op     = ALU_PASS;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SEQ;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        instr_d = decode_op(opcode);
        cnt_d   = '0;
        state_d = (decode_op(opcode) == I_NONE) ? S_ERROR : S_EXEC;
      end

      S_EXEC: begin
        cnt_d = cnt_q + CNT_W'(1);
        case (instr_q)
          I_ADDI: begin alu_op = ALU_ADD; alu_src = 1'b1; end
          I_ADDS: begin alu_op = ALU_ADD; flag_en = exec_last; end
          I_SUBS: begin alu_op = ALU_SUB; flag_en = exec_last; end
          I_LSL:  begin alu_op = ALU_SHIFT; alu_src = 1'b1; end
          I_LSR:  begin alu_op = ALU_SHIFT; alu_src = 1'b1; shift_dir = 1'b1; end
          I_MUL:  alu_op = ALU_MUL;
          I_LDUR: begin alu_op = ALU_ADD; alu_src = 1'b1; end
          I_STUR: begin alu_op = ALU_ADD; alu_src = 1'b1; reg2loc = 1'b1; end
          I_CBZ: begin
            alu_op   = ALU_PASS;
            reg2loc  = 1'b1;
            br_taken = zero;
            pc_write = br_taken;
            pc_src   = br_taken ? PC_COND : PC_SEQ;
          end
          I_BLT: begin
            br_taken = flag_n ^ flag_v;
            pc_write = br_taken;
            pc_src   = br_taken ? PC_COND : PC_SEQ;
          end
          I_B: begin
            pc_write = 1'b1;
            pc_src   = PC_UNCOND;
          end
          default: ;
        endcase
        if (exec_last) begin
          case (instr_q)
            I_LDUR, I_STUR:  state_d = S_MEM;
            I_B, I_BLT, I_CBZ: state_d = S_FETCH;
            default:         state_d = S_WB;
          endcase
        end
      end

      S_MEM: begin
        dmem_req  = 1'b1;
        mem_read  = (instr_q == I_LDUR);
        mem_write = (instr_q == I_STUR);
        if (dmem_ack) begin
          state_d = (instr_q == I_LDUR) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (instr_q == I_LDUR);
        state_d    = S_FETCH;
      end

      S_ERROR: illegal = 1'b1;

      default: state_d = S_FETCH;
    endcase

    // Reset wins over everything: all strobes low while it is held
    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg2loc    = 1'b0;
      shift_dir  = 1'b0;
      flag_en    = 1'b0;
      pc_src     = PC_SEQ;
      alu_op     = ALU_PASS;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds a per-cycle stimulus/expected trace from instruction-level
// rules, then replays it, checking every output every cycle.
module tb_multicycle_ctrl;

  localparam int unsigned MC = 4;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg2loc;
    logic       shift_dir;
    logic       flag_en;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic        rst;
    logic        iack;
    logic        dack;
    logic        z;
    logic        n;
    logic        v;
    logic [10:0] op;
    outs_t       exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        imem_ack, dmem_ack, zero, flag_n, flag_v;
  logic        imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write;
  logic        mem_to_reg, alu_src, reg2loc, shift_dir, flag_en, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;

  cyc_t  q[$];
  string tags[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero),
    .flag_n(flag_n), .flag_v(flag_v),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .reg2loc(reg2loc), .shift_dir(shift_dir), .flag_en(flag_en),
    .pc_src(pc_src), .alu_op(alu_op), .illegal(illegal)
  );

  function automatic string classify(input logic [10:0] op);
    if (op ==? 11'b1001000100?) return "ADDI";
    if (op == 11'b10101011000)  return "ADDS";
    if (op == 11'b11101011000)  return "SUBS";
    if (op == 11'b11010011011)  return "LSL";
    if (op == 11'b11010011010)  return "LSR";
    if (op == 11'b10011011000)  return "MUL";
    if (op == 11'b11111000010)  return "LDUR";
    if (op == 11'b11111000000)  return "STUR";
    if (op ==? 11'b000101?????) return "B";
    if (op ==? 11'b01010100???) return "BLT";
    if (op ==? 11'b10110100???) return "CBZ";
    return "ILL";
  endfunction

  function automatic cyc_t blank(input logic [10:0] op, input logic z, input logic n, input logic v);
    cyc_t c;
    c = '0;
    c.op = op; c.z = z; c.n = n; c.v = v;
    return c;
  endfunction

  task automatic push(input cyc_t c, input string tag);
    q.push_back(c);
    tags.push_back(tag);
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL pin %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One instruction worth of cycles. mem_rst_at >= 0 asserts reset on that MEM cycle instead.
  task automatic gen_instr(input logic [10:0] op, input int wi, input int wd,
                           input logic z, input logic n, input logic v,
                           input int mem_rst_at);
    cyc_t  c;
    string k;
    int    nexec;
    k = classify(op);
    for (int i = 0; i < wi; i++) begin
      c = blank(op, z, n, v); c.dack = 1'b1; c.exp.imem_req = 1'b1;
      push(c, {k, "-fetchwait"});
    end
    c = blank(op, z, n, v); c.iack = 1'b1;
    c.exp.imem_req = 1'b1; c.exp.ir_write = 1'b1; c.exp.pc_write = 1'b1;
    push(c, {k, "-fetch"});
    c = blank(op, z, n, v); c.iack = 1'b1; c.dack = 1'b1;
    push(c, {k, "-decode"});
    if (k == "ILL") begin
      for (int i = 0; i < 10; i++) begin
        c = blank(op, z, n, v); c.iack = 1'b1; c.dack = 1'b1; c.exp.illegal = 1'b1;
        push(c, "error");
      end
      c = blank(op, z, n, v); c.rst = 1'b1;
      push(c, "error-reset");
      return;
    end
    nexec = (k == "MUL") ? MC : 1;
    for (int e = 0; e < nexec; e++) begin
      c = blank(op, z, n, v); c.iack = 1'b1; c.dack = 1'b1;
      case (k)
        "ADDI": begin c.exp.alu_op = 3'b010; c.exp.alu_src = 1'b1; end
        "ADDS": begin c.exp.alu_op = 3'b010; c.exp.flag_en = 1'b1; end
        "SUBS": begin c.exp.alu_op = 3'b011; c.exp.flag_en = 1'b1; end
        "LSL":  begin c.exp.alu_op = 3'b001; c.exp.alu_src = 1'b1; end
        "LSR":  begin c.exp.alu_op = 3'b001; c.exp.alu_src = 1'b1; c.exp.shift_dir = 1'b1; end
        "MUL":  c.exp.alu_op = 3'b111;
        "LDUR": begin c.exp.alu_op = 3'b010; c.exp.alu_src = 1'b1; end
        "STUR": begin c.exp.alu_op = 3'b010; c.exp.alu_src = 1'b1; c.exp.reg2loc = 1'b1; end
        "CBZ":  begin c.exp.reg2loc = 1'b1; c.exp.pc_write = z; c.exp.pc_src = z ? 2'b01 : 2'b00; end
        "BLT":  begin c.exp.pc_write = n ^ v; c.exp.pc_src = (n ^ v) ? 2'b01 : 2'b00; end
        "B":    begin c.exp.pc_write = 1'b1; c.exp.pc_src = 2'b10; end
        default: ;
      endcase
      push(c, {k, "-exec"});
    end
    if (k == "LDUR" || k == "STUR") begin
      for (int i = 0; i <= wd; i++) begin
        c = blank(op, z, n, v); c.iack = 1'b1; c.dack = (i == wd);
        c.exp.dmem_req  = 1'b1;
        c.exp.mem_read  = (k == "LDUR");
        c.exp.mem_write = (k == "STUR");
        if (i == mem_rst_at) begin
          c.rst = 1'b1; c.dack = 1'b0; c.exp = '0;
          push(c, "mem-reset");
          return;
        end
        push(c, {k, "-mem"});
      end
    end
    if (k != "STUR" && k != "B" && k != "BLT" && k != "CBZ") begin
      c = blank(op, z, n, v); c.iack = 1'b1; c.dack = 1'b1;
      c.exp.reg_write = 1'b1; c.exp.mem_to_reg = (k == "LDUR");
      push(c, {k, "-wb"});
    end
  endtask

  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_ADDI1 = 11'b10010001001;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LSL   = 11'b11010011011;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_MUL   = 11'b10011011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_B     = 11'b00010110101;
  localparam logic [10:0] OP_BLT   = 11'b01010100011;
  localparam logic [10:0] OP_CBZ   = 11'b10110100110;

  initial begin
    cyc_t  c;
    outs_t act;
    int    base;

    reset = 1'b1; opcode = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
    zero = 1'b0; flag_n = 1'b0; flag_v = 1'b0;

    for (int i = 0; i < 2; i++) begin
      c = blank(11'h7ff, 1'b0, 1'b0, 1'b0); c.rst = 1'b1; c.iack = 1'b1; c.dack = 1'b1;
      push(c, "reset");
    end

    base = q.size(); gen_instr(OP_ADDI, 0, 0, 0, 0, 0, -1);
    pin("lat-addi", q.size() - base, 4);
    pin("addi-fetch", int'(q[base].exp), 'h2C000);
    pin("addi-exec", int'(q[base + 2].exp), 'h00204);
    pin("addi-wb", int'(q[base + 3].exp), 'h02000);
    gen_instr(OP_ADDS, 2, 0, 0, 0, 0, -1);
    gen_instr(OP_SUBS, 0, 0, 0, 0, 0, -1);
    gen_instr(OP_LSL,  1, 0, 0, 0, 0, -1);
    gen_instr(OP_LSR,  0, 0, 0, 0, 0, -1);
    base = q.size(); gen_instr(OP_MUL, 0, 0, 0, 0, 0, -1);
    pin("lat-mul", q.size() - base, 3 + MC);
    base = q.size(); gen_instr(OP_LDUR, 0, 0, 0, 0, 0, -1);
    pin("lat-ldur", q.size() - base, 5);
    base = q.size(); gen_instr(OP_LDUR, 0, 3, 0, 0, 0, -1);
    pin("ldur-wb", int'(q[base + 7].exp), 'h02400);
    base = q.size(); gen_instr(OP_STUR, 0, 0, 0, 0, 0, -1);
    pin("lat-stur", q.size() - base, 4);
    base = q.size(); gen_instr(OP_CBZ, 0, 0, 0, 0, 0, -1);
    pin("lat-br", q.size() - base, 3);
    gen_instr(OP_CBZ, 0, 0, 1, 0, 0, -1);
    gen_instr(OP_BLT, 0, 0, 0, 1, 0, -1);
    gen_instr(OP_BLT, 0, 0, 0, 1, 1, -1);
    gen_instr(OP_BLT, 0, 0, 0, 0, 1, -1);
    base = q.size(); gen_instr(OP_B, 1, 0, 0, 0, 0, -1);
    pin("b-exec", int'(q[base + 3].exp), 'h04020);
    gen_instr(OP_STUR, 0, 3, 0, 0, 0, 1);
    gen_instr(OP_ADDI1, 0, 0, 0, 0, 0, -1);
    gen_instr(11'b00000000000, 0, 0, 0, 0, 0, -1);
    gen_instr(OP_ADDI, 0, 0, 0, 0, 0, -1);
    gen_instr(11'b11111111111, 1, 0, 0, 0, 0, -1);
    gen_instr(OP_MUL, 0, 0, 0, 0, 0, -1);

    // Replay: drive on the falling edge, sample just after, well before the next rising edge
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      reset = q[i].rst; opcode = q[i].op;
      imem_ack = q[i].iack; dmem_ack = q[i].dack;
      zero = q[i].z; flag_n = q[i].n; flag_v = q[i].v;
      #1;
      act = '{imem_req, dmem_req, ir_write, pc_write, reg_write, mem_read, mem_write,
              mem_to_reg, alu_src, reg2loc, shift_dir, flag_en, pc_src, alu_op, illegal};
      total++;
      if (act !== q[i].exp) begin
        bad++;
        $display("FAIL cyc%0d %s got=%05h want=%05h", i, tags[i], act, q[i].exp);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
